alu_pipe: RTL



---
 rtl/alu_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides,
// a {V,N,Z,C} status output and an internal accumulator.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_valid      operand beat present
//   in_ready      beat is accepted this cycle when in_valid is also high
//   in_ope        opcode (0 or, 1 and, 2 xor, 3 xnor, 4 not A, 5 not B, 6 add, 7 sub)
//   in_a, in_b    operands; in_a is replaced by the accumulator when in_use_acc=1
//   in_use_acc    take operand A from the accumulator
//   in_acc_we     write result[WIDTH-1:0] back into the accumulator
//   out_valid     result beat present
//   out_ready     consumer accepts the result this cycle
//   out_res       result, bit WIDTH is carry (add) / borrow (sub)
//   out_flags     {V,N,Z,C}
//   acc           current accumulator value
//
// Pipeline: S1 holds the accepted operands, S2 holds the computed result.
// The accumulator is written when an acc_we beat moves S1->S2, so a beat that
// wants to read the accumulator is held off while such a write sits in S1.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_ope,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_use_acc,
  input  logic             in_acc_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_res,
  output logic [3:0]       out_flags,
  output logic [WIDTH-1:0] acc
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_OR   = 3'd0,
    OP_AND  = 3'd1,
    OP_XOR  = 3'd2,
    OP_XNOR = 3'd3,
    OP_NOTA = 3'd4,
    OP_NOTB = 3'd5,
    OP_ADD  = 3'd6,
    OP_SUB  = 3'd7
  } op_e;

  // Stage 1 registers
  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_acc_we;

  // Stage 2 registers
  logic             s2_valid;
  logic [WIDTH:0]   res_q;
  logic [3:0]       flags_q;

  logic [WIDTH-1:0] acc_q;

  // Handshake / advance
  logic s2_free;
  logic s1_move;
  logic s1_free;
  logic hazard;
  logic accept;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_move  = s1_valid && s2_free;
  assign s1_free  = !s1_valid || s1_move;
  // No forwarding: a reader of the accumulator waits until the pending write
  // in S1 has landed.
  assign hazard   = in_use_acc && s1_valid && s1_acc_we;
  assign in_ready = s1_free && !hazard;
  assign accept   = in_valid && in_ready;

  // Result computation from S1
  logic [WIDTH:0]   res_c;
  logic             ovf_c;
  logic [3:0]       flags_c;
  logic [WIDTH:0]   a_x;
  logic [WIDTH:0]   b_x;

  assign a_x = {1'b0, s1_a};
  assign b_x = {1'b0, s1_b};

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (s1_op)
      OP_OR:   res_c = a_x | b_x;
      OP_AND:  res_c = a_x & b_x;
      OP_XOR:  res_c = a_x ^ b_x;
      OP_XNOR: res_c = {1'b0, ~(s1_a ^ s1_b)};
      OP_NOTA: res_c = {1'b0, ~s1_a};
      OP_NOTB: res_c = {1'b0, ~s1_b};
      OP_ADD: begin
        res_c = a_x + b_x;
        ovf_c = (s1_a[MSB] == s1_b[MSB]) && (res_c[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        // Modulo 2^(WIDTH+1): bit WIDTH becomes the unsigned borrow.
        res_c = a_x - b_x;
        ovf_c = (s1_a[MSB] != s1_b[MSB]) && (res_c[MSB] != s1_a[MSB]);
      end
      default: res_c = '0;
    endcase
  end

  assign flags_c = {ovf_c, res_c[MSB], (res_c[MSB:0] == '0), res_c[WIDTH]};

  // Stage 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_OR;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_acc_we <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_op     <= op_e'(in_ope);
        s1_a      <= in_use_acc ? acc_q : in_a;
        s1_b      <= in_b;
        s1_acc_we <= in_acc_we;
      end else if (s1_move) begin
        s1_valid  <= 1'b0;
      end
    end
  end

  // Stage 2 and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      res_q    <= '0;
      flags_q  <= '0;
      acc_q    <= '0;
    end else begin
      if (s1_move) begin
        s2_valid <= 1'b1;
        res_q    <= res_c;
        flags_q  <= flags_c;
        if (s1_acc_we) begin
          acc_q <= res_c[MSB:0];
        end
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_res   = res_q;
  assign out_flags = flags_q;
  assign acc       = acc_q;

endmodule
